// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side status in, stall/flush/bubble controls out.
interface hazard_ctrl_if;
    logic       id_valid;
    logic [4:0] id_read_reg1;
    logic [4:0] id_read_reg2;
    logic       id_hlt;
    logic       ex_mem_reg;
    logic [4:0] ex_write_reg;
    logic       ex_mul;
    logic       ex_branch_taken;
    logic       pc_stall;
    logic       if_id_stall;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       ex_hold;
    logic       halted;
    logic [1:0] state;

    modport master (
        output id_valid, id_read_reg1, id_read_reg2, id_hlt,
        output ex_mem_reg, ex_write_reg, ex_mul, ex_branch_taken,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, halted, state
    );

    modport slave (
        input  id_valid, id_read_reg1, id_read_reg2, id_hlt,
        input  ex_mem_reg, ex_write_reg, ex_mul, ex_branch_taken,
        output pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, halted, state
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller with load-use stall, branch flush, multicycle multiply and halt drain.
module hazard_ctrl #(
    parameter int MUL_CYCLES   = 4,
    parameter int DRAIN_CYCLES = 4
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'b00, MUL = 2'b01, DRAIN = 2'b10, HALT = 2'b11} state_t;

    localparam logic [3:0] MUL_INIT   = 4'(MUL_CYCLES - 2);
    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic       w_load_use;
    logic       w_pc_stall, w_if_id_stall, w_if_id_flush, w_id_ex_bubble, w_ex_hold, w_halted;

    assign w_load_use = bus.ex_mem_reg && (bus.ex_write_reg != 5'd0) && bus.id_valid &&
                        ((bus.ex_write_reg == bus.id_read_reg1) || (bus.ex_write_reg == bus.id_read_reg2));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_pc_stall     = 1'b0;
        w_if_id_stall  = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_ex_hold      = 1'b0;
        w_halted       = 1'b0;
        case (r_state)
            RUN: begin
                if (bus.ex_mul) begin
                    w_ex_hold     = 1'b1;
                    w_pc_stall    = 1'b1;
                    w_if_id_stall = 1'b1;
                    w_state_nxt   = MUL;
                    w_cnt_nxt     = MUL_INIT;
                end else if (bus.ex_branch_taken) begin
                    w_if_id_flush  = 1'b1;
                    w_id_ex_bubble = 1'b1;
                end else if (w_load_use) begin
                    w_pc_stall     = 1'b1;
                    w_if_id_stall  = 1'b1;
                    w_id_ex_bubble = 1'b1;
                end else if (bus.id_hlt && bus.id_valid) begin
                    // hlt stays parked in ID; only bubbles reach EX from here on
                    w_pc_stall     = 1'b1;
                    w_if_id_stall  = 1'b1;
                    w_id_ex_bubble = 1'b1;
                    w_state_nxt    = DRAIN;
                    w_cnt_nxt      = DRAIN_INIT;
                end
            end
            MUL: begin
                if (r_cnt != 4'd0) begin
                    w_ex_hold     = 1'b1;
                    w_pc_stall    = 1'b1;
                    w_if_id_stall = 1'b1;
                    w_cnt_nxt     = r_cnt - 4'd1;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DRAIN: begin
                w_pc_stall     = 1'b1;
                w_if_id_stall  = 1'b1;
                w_id_ex_bubble = 1'b1;
                w_state_nxt    = (r_cnt == 4'd0) ? HALT : DRAIN;
                w_cnt_nxt      = (r_cnt == 4'd0) ? r_cnt : r_cnt - 4'd1;
            end
            default: begin
                w_pc_stall     = 1'b1;
                w_if_id_stall  = 1'b1;
                w_id_ex_bubble = 1'b1;
                w_halted       = 1'b1;
            end
        endcase
    end

    // reset masks every output immediately, before the state register clears
    assign bus.pc_stall     = w_pc_stall & ~rst;
    assign bus.if_id_stall  = w_if_id_stall & ~rst;
    assign bus.if_id_flush  = w_if_id_flush & ~rst;
    assign bus.id_ex_bubble = w_id_ex_bubble & ~rst;
    assign bus.ex_hold      = w_ex_hold & ~rst;
    assign bus.halted       = w_halted & ~rst;
    assign bus.state        = rst ? 2'b00 : r_state;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors on two parameterisations, checked every cycle against a window-based model.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic       id_valid, id_hlt, ex_mem_reg, ex_mul, ex_branch_taken;
    logic [4:0] id_read_reg1, id_read_reg2, ex_write_reg;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if b4 ();
    hazard_ctrl_if b2 ();

    assign b4.id_valid = id_valid;       assign b2.id_valid = id_valid;
    assign b4.id_read_reg1 = id_read_reg1; assign b2.id_read_reg1 = id_read_reg1;
    assign b4.id_read_reg2 = id_read_reg2; assign b2.id_read_reg2 = id_read_reg2;
    assign b4.id_hlt = id_hlt;           assign b2.id_hlt = id_hlt;
    assign b4.ex_mem_reg = ex_mem_reg;   assign b2.ex_mem_reg = ex_mem_reg;
    assign b4.ex_write_reg = ex_write_reg; assign b2.ex_write_reg = ex_write_reg;
    assign b4.ex_mul = ex_mul;           assign b2.ex_mul = ex_mul;
    assign b4.ex_branch_taken = ex_branch_taken; assign b2.ex_branch_taken = ex_branch_taken;

    hazard_ctrl #(.MUL_CYCLES(4), .DRAIN_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    hazard_ctrl #(.MUL_CYCLES(2), .DRAIN_CYCLES(1)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    // packed view: {state[1:0], pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, halted}
    logic [7:0] o4, o2;
    assign o4 = {b4.state, b4.pc_stall, b4.if_id_stall, b4.if_id_flush, b4.id_ex_bubble, b4.ex_hold, b4.halted};
    assign o2 = {b2.state, b2.pc_stall, b2.if_id_stall, b2.if_id_flush, b2.id_ex_bubble, b2.ex_hold, b2.halted};

    localparam logic [7:0] IDLE    = 8'b00_000000;
    localparam logic [7:0] LU      = 8'b00_110100;
    localparam logic [7:0] BR      = 8'b00_001100;
    localparam logic [7:0] MUL_ACC = 8'b00_110010;
    localparam logic [7:0] MUL_HLD = 8'b01_110010;
    localparam logic [7:0] MUL_END = 8'b01_000000;
    localparam logic [7:0] HLT_ACC = 8'b00_110100;
    localparam logic [7:0] DRN     = 8'b10_110100;
    localparam logic [7:0] HLTD    = 8'b11_110101;

    function automatic logic load_use();
        return ex_mem_reg && ex_write_reg != 5'd0 && id_valid &&
               (ex_write_reg == id_read_reg1 || ex_write_reg == id_read_reg2);
    endfunction

    // Model: a multiply accepted at cycle ms occupies EX for cycles ms..ms+M-1 with hold on all but the last;
    // a halt accepted at cycle ha drains during ha+1..ha+D and is halted from ha+D+1 onward.
    function automatic logic [7:0] model(int m, int d, int c, int ms, int ha);
        if (rst) return IDLE;
        if (ha >= 0) return (c > ha + d) ? HLTD : DRN;
        if (ms >= 0 && c > ms && c <= ms + m - 1) return (c < ms + m - 1) ? MUL_HLD : MUL_END;
        if (ex_mul) return MUL_ACC;
        if (ex_branch_taken) return BR;
        if (load_use()) return LU;
        if (id_hlt && id_valid) return HLT_ACC;
        return IDLE;
    endfunction

    task automatic check_model(string n, int m, int d, int c, logic [7:0] got, inout int ms, inout int ha);
        logic [7:0] e;
        e = model(m, d, c, ms, ha);
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %b expected %b", n, c, got, e);
        end
        if (rst) begin
            ms = -1;
            ha = -1;
        end else if (e == MUL_ACC) ms = c;
        else if (e == HLT_ACC && !load_use()) ha = c;
    endtask

    initial begin
        int c = 0;
        int ms4 = -1, ha4 = -1, ms2 = -1, ha2 = -1;
        forever begin
            @(negedge clk);
            if (!rst && ex_mul && ex_branch_taken)
                $display("illegal stimulus: ex_mul with ex_branch_taken at cycle %0d", c);
            check_model("model_m4d4", 4, 4, c, o4, ms4, ha4);
            check_model("model_m2d1", 2, 1, c, o2, ms2, ha2);
            c++;
        end
    end

    task automatic lit(string n, logic [7:0] got, logic [7:0] e);
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", n, got, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(logic v, logic [4:0] r1, logic [4:0] r2, logic h, logic mr, logic [4:0] wr, logic m, logic b);
        id_valid = v; id_read_reg1 = r1; id_read_reg2 = r2; id_hlt = h;
        ex_mem_reg = mr; ex_write_reg = wr; ex_mul = m; ex_branch_taken = b;
    endtask

    task automatic clr();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        drv(1, 5, 0, 1, 1, 5, 1, 0);
        tick(); #1 lit("rst_forced_m4", o4, IDLE); lit("rst_forced_m2", o2, IDLE);
        tick(); rst = 1'b0; clr(); #1 lit("idle", o4, IDLE);
        tick(); drv(1, 5, 0, 0, 1, 5, 0, 0); #1 lit("load_use_r1", o4, LU);
        tick(); clr(); #1 lit("after_load_use", o4, IDLE);
        tick(); drv(1, 3, 5, 0, 1, 5, 0, 0); #1 lit("load_use_r2", o4, LU);
        tick(); drv(1, 0, 0, 0, 1, 0, 0, 0); #1 lit("x0_no_hazard", o4, IDLE);
        tick(); drv(0, 5, 5, 0, 1, 5, 0, 0); #1 lit("bubble_no_hazard", o4, IDLE);
        tick(); drv(0, 0, 0, 0, 0, 0, 1, 0); #1 lit("mul_c0", o4, MUL_ACC); lit("mul2_c0", o2, MUL_ACC);
        tick(); drv(0, 0, 0, 0, 0, 0, 0, 1); #1 lit("mul_c1", o4, MUL_HLD); lit("mul2_c1", o2, MUL_END);
        tick(); drv(1, 7, 0, 1, 1, 7, 0, 0); #1 lit("mul_c2", o4, MUL_HLD);
        tick(); clr(); #1 lit("mul_c3", o4, MUL_END);
        tick(); #1 lit("mul_done", o4, IDLE);
        tick(); drv(1, 9, 0, 0, 1, 9, 0, 1); #1 lit("branch_and_load_use", o4, BR);
        tick(); drv(1, 0, 0, 1, 0, 0, 0, 1); #1 lit("branch_and_hlt", o4, BR);
        tick(); clr(); #1 lit("hlt_wrong_path_ignored", o4, IDLE);
        tick(); drv(0, 0, 0, 1, 0, 0, 0, 0); #1 lit("hlt_without_valid", o4, IDLE);
        tick(); drv(0, 0, 0, 0, 0, 0, 1, 1); #1 lit("mul_beats_branch", o4, MUL_ACC);
        for (int i = 0; i < 4; i++) begin tick(); clr(); end
        #1 lit("mul_branch_done", o4, IDLE);
        tick(); drv(1, 0, 0, 1, 0, 0, 0, 0); #1 lit("hlt_accept", o4, HLT_ACC); lit("hlt2_accept", o2, HLT_ACC);
        tick(); drv(0, 0, 0, 0, 0, 0, 1, 1); #1 lit("drain_1", o4, DRN); lit("drain2_1", o2, DRN);
        tick(); #1 lit("drain_2", o4, DRN); lit("halt2", o2, HLTD);
        tick(); #1 lit("drain_3", o4, DRN);
        tick(); #1 lit("drain_4", o4, DRN);
        for (int i = 0; i < 4; i++) begin tick(); #1 lit("halt_held", o4, HLTD); end
        tick(); rst = 1'b1; #1 lit("rst_in_halt", o4, IDLE); lit("rst2_in_halt", o2, IDLE);
        tick(); rst = 1'b0; clr(); #1 lit("after_rst_halt", o4, IDLE);
        tick(); drv(1, 0, 0, 1, 0, 0, 0, 0); #1 lit("hlt_accept_b", o4, HLT_ACC);
        tick(); clr(); #1 lit("drain_b1", o4, DRN);
        tick(); #1 lit("drain_b2", o4, DRN);
        tick(); rst = 1'b1; #1 lit("rst_in_drain", o4, IDLE);
        tick(); rst = 1'b0; #1 lit("after_rst_drain", o4, IDLE);
        tick(); drv(1, 4, 0, 0, 1, 4, 0, 0); #1 lit("run_after_rst", o4, LU);
        tick(); drv(0, 0, 0, 0, 0, 0, 1, 0); #1 lit("mul_b_c0", o4, MUL_ACC);
        tick(); clr(); #1 lit("mul_b_c1", o4, MUL_HLD);
        tick(); rst = 1'b1; #1 lit("rst_in_mul", o4, IDLE);
        tick(); rst = 1'b0; #1 lit("after_rst_mul", o4, IDLE);
        tick(); drv(0, 0, 0, 0, 0, 0, 1, 0); #1 lit("mul_c_c0", o4, MUL_ACC);
        tick(); clr(); #1 lit("mul_c_c1", o4, MUL_HLD);
        for (int i = 0; i < 3; i++) tick();
        #1 lit("mul_c_done", o4, IDLE);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MUL_CYCLES, default 4: total cycles a multiply (ALUop 3'b111) occupies EX; legal range 2..16.
REQ-002 Parameter DRAIN_CYCLES, default 4: cycles spent emptying the pipeline after a halt is accepted; legal range 1..16.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 id_valid  in  1  ID holds a real instruction (low for a bubble).
REQ-006 id_read_reg1, id_read_reg2  in  5 each  source registers of the ID instruction.
REQ-007 id_hlt  in  1  decoder halt flag for the ID instruction.
REQ-008 ex_mem_reg  in  1  EX instruction is a load.
REQ-009 ex_write_reg  in  5  destination register of the EX instruction.
REQ-010 ex_mul  in  1  EX instruction is a valid multiply.
REQ-011 ex_branch_taken  in  1  EX resolved a taken branch, jal or jalr redirect.
REQ-012 pc_stall  out  1  PC holds its value.
REQ-013 if_id_stall  out  1  IF/ID register holds its value.
REQ-014 if_id_flush  out  1  IF/ID loads a bubble.
REQ-015 id_ex_bubble  out  1  ID/EX loads a bubble; drives the decoder bubble input.
REQ-016 ex_hold  out  1  ID/EX and EX hold; EX/MEM loads a bubble.
REQ-017 halted  out  1  processor is stopped.
REQ-018 state  out  2  FSM state: RUN=00, MUL=01, DRAIN=10, HALT=11.

Function
REQ-019 The FSM SHALL have four states (RUN, MUL, DRAIN, HALT) and a 4-bit down-counter cnt; all outputs are combinational from state, cnt and inputs.
REQ-020 load_use SHALL be asserted when ex_mem_reg=1, ex_write_reg!=0, id_valid=1, and ex_write_reg equals id_read_reg1 or id_read_reg2; register x0 never produces a hazard.
REQ-021 RUN, priority 1: when ex_mul=1, ex_hold, pc_stall and if_id_stall SHALL be 1, with next state MUL and cnt=MUL_CYCLES-2; ex_branch_taken, load_use and id_hlt are ignored that cycle.
REQ-022 RUN, priority 2: when ex_branch_taken=1, if_id_flush and id_ex_bubble SHALL be 1 and pc_stall SHALL be 0; load_use and id_hlt are ignored as wrong-path.
REQ-023 RUN, priority 3: when load_use=1, pc_stall, if_id_stall and id_ex_bubble SHALL be 1 for exactly that cycle; state stays RUN.
REQ-024 RUN, priority 4: when id_hlt=1 and id_valid=1, the halt is accepted: pc_stall, if_id_stall and id_ex_bubble SHALL be 1, next state DRAIN, cnt=DRAIN_CYCLES-1; the hlt instruction never enters EX.
REQ-025 RUN with none of the above SHALL drive all control outputs to 0.
REQ-026 MUL, cnt!=0: ex_hold, pc_stall and if_id_stall SHALL be 1 and cnt decrements; all ex_* and id_* inputs are ignored.
REQ-027 MUL, cnt==0: all control outputs SHALL be 0 so the multiply advances, with next state RUN; total EX occupancy is exactly MUL_CYCLES cycles, and ex_hold is high for MUL_CYCLES-1 consecutive cycles.
REQ-028 DRAIN: pc_stall, if_id_stall and id_ex_bubble SHALL be 1 and all ex_* and id_* inputs are ignored; cnt decrements, and at cnt==0 the next state is HALT.
REQ-029 HALT: pc_stall, if_id_stall, id_ex_bubble and halted SHALL be 1, and the state is held until rst.
REQ-030 if_id_flush SHALL be asserted only in RUN, and ex_hold only in RUN or MUL.
REQ-031 Simultaneous ex_mul and ex_branch_taken is illegal; the bench SHALL flag it, and the RTL resolves it per REQ-021.

Reset
REQ-032 When rst=1 at a rising edge, the next state SHALL be RUN and cnt SHALL be 0, from any state, including mid-MUL and mid-DRAIN.
REQ-033 While rst=1, all outputs SHALL be forced to 0 and state SHALL read 00.

Verification
REQ-034 Load-use: load writes x5 in EX, ID reads x5 -> one cycle with pc_stall=if_id_stall=id_ex_bubble=1, then all 0; repeat with ex_write_reg=0 -> no stall.
REQ-035 Multiply (MUL_CYCLES=4): ex_mul pulse in RUN -> ex_hold high for 3 cycles, state 00,01,01,01 then 00, outputs 0 in the 4th cycle; MUL_CYCLES=2 -> ex_hold high for 1 cycle.
REQ-036 Branch and load-use together: ex_branch_taken=1 and load_use=1 -> if_id_flush=id_ex_bubble=1 and pc_stall=0.
REQ-037 Halt (DRAIN_CYCLES=4): id_hlt with id_valid -> 1 acceptance cycle, then 4 DRAIN cycles, then HALT with halted=1 held indefinitely; id_hlt in the same cycle as ex_branch_taken -> ignored, state stays 00.
REQ-038 Reset mid-operation: rst asserted in the 2nd MUL cycle, and separately in DRAIN and in HALT -> outputs 0 during rst and state 00 on the following cycle.
